// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the mux truth-table scan controller.
package tt_scan_pkg;

  localparam int N_VEC          = 16;
  localparam int IDX_W          = 4;
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_e;

  // Lowest bit position where the two tables disagree; 0 when they match.
  function automatic logic [IDX_W-1:0] first_diff(input logic [N_VEC-1:0] a,
                                                  input logic [N_VEC-1:0] b);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_VEC - 1; i >= 0; i--) begin
      if (a[i] != b[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/tt_vec_counter.sv
// Vector index and per-vector settle counter for the scan controller.
module tt_vec_counter
  import tt_scan_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             settle_run_i,
  input  logic             step_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_settle_o,
  output logic             last_vec_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;

  assign last_settle_o = (cnt_q == 4'(SETTLE_CYC - 1));
  assign last_vec_o    = (idx_q == IDX_W'(N_VEC - 1));
  assign idx_o         = idx_q;

  // The settle counter self-clears on the last cycle so back-to-back vectors restart at 0.
  always_comb begin
    idx_d = idx_q;
    cnt_d = '0;
    if (clr_i) begin
      idx_d = '0;
    end else if (step_i && !last_vec_o) begin
      idx_d = idx_q + 1'b1;
    end
    if (settle_run_i && !last_settle_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_scan_ctrl.sv
// Sweeps all 16 {a,b,c,d} vectors through a strobed 8:1 mux and records its truth table.
module tt_scan_ctrl
  import tt_scan_pkg::*;
#(
  parameter int SETTLE_CYC     = SETTLE_CYC_DEF,
  parameter bit SAMPLE_ON_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_VEC-1:0] expect_mask,
  output logic [IDX_W-1:0] abcd,
  output logic             sn,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic             pass,
  output logic             blank_err,
  output logic [IDX_W-1:0] err_idx
);

  state_e           state_q, state_d;
  logic [N_VEC-1:0] exp_q, exp_d;
  logic [N_VEC-1:0] shadow_q, shadow_d;
  logic [N_VEC-1:0] table_q, table_d;
  logic             pass_q, pass_d;
  logic [IDX_W-1:0] err_q, err_d;
  logic             blank_q, blank_d;
  logic             done_q, done_d;

  logic             accept;
  logic             sample_fire;
  logic             settle_run;
  logic [IDX_W-1:0] idx;
  logic             last_settle;
  logic             last_vec;

  assign accept     = (state_q == S_IDLE) && start && !abort;
  assign settle_run = (state_q == S_DRIVE) && !abort;

  tt_vec_counter #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (accept),
    .settle_run_i (settle_run),
    .step_i       (sample_fire),
    .idx_o        (idx),
    .last_settle_o(last_settle),
    .last_vec_o   (last_vec)
  );

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    shadow_d    = shadow_q;
    table_d     = table_q;
    pass_d      = pass_q;
    err_d       = err_q;
    blank_d     = blank_q;
    done_d      = 1'b0;
    sample_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_BLANK;
          exp_d    = expect_mask;
          shadow_d = '0;
        end
      end
      S_BLANK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          blank_d = ~y_in;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_settle) begin
          // Early sampling folds the SAMPLE step into the final settle cycle.
          if (SAMPLE_ON_LAST) begin
            sample_fire = 1'b1;
            state_d     = last_vec ? S_DONE : S_DRIVE;
          end else begin
            state_d = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          sample_fire = 1'b1;
          state_d     = last_vec ? S_DONE : S_DRIVE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        table_d = shadow_q;
        pass_d  = (shadow_q == exp_q);
        err_d   = first_diff(shadow_q, exp_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (sample_fire) shadow_d[idx] = y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      exp_q    <= '0;
      shadow_q <= '0;
      table_q  <= '0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      blank_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      table_q  <= table_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
    end
  end

  assign abcd      = idx;
  assign sn        = !((state_q == S_DRIVE) || (state_q == S_SAMPLE));
  assign busy      = (state_q == S_BLANK) || (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done      = done_q;
  assign table_out = table_q;
  assign pass      = pass_q;
  assign blank_err = blank_q;
  assign err_idx   = err_q;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Directed bench: scan controller closed-loop with a behavioural strobed 8:1 mux.
module tb_tt_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expect_mask = '0;
  logic [3:0]  abcd;
  logic        sn;
  logic        y_in;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        pass;
  logic        blank_err;
  logic [3:0]  err_idx;

  logic [15:0] fn = '0;
  logic        force0 = 1'b0;

  int total = 0;
  int bad = 0;

  logic       busy_r [0:79];
  logic       sn_r   [0:79];
  logic       blank_r[0:79];
  logic [3:0] abcd_r [0:79];
  int         done_k;
  int         n_done;
  int         cnt;
  logic       hit;

  always #5 clk = ~clk;

  // Strobed 8:1 mux: select {a,b,c}, each data input derived from d; disabled output is 1.
  always_comb begin
    if (sn) y_in = ~force0;
    else    y_in = abcd[0] ? fn[{abcd[3:1], 1'b1}] : fn[{abcd[3:1], 1'b0}];
  end

  tt_scan_ctrl #(
    .SETTLE_CYC    (2),
    .SAMPLE_ON_LAST(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .expect_mask(expect_mask),
    .abcd       (abcd),
    .sn         (sn),
    .y_in       (y_in),
    .busy       (busy),
    .done       (done),
    .table_out  (table_out),
    .pass       (pass),
    .blank_err  (blank_err),
    .err_idx    (err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic record(input int k);
    busy_r[k]  = busy;
    sn_r[k]    = sn;
    blank_r[k] = blank_err;
    abcd_r[k]  = abcd;
  endtask

  // Start edge is k=0; samples are taken 1 time unit after every following edge.
  task automatic sweep(input logic [15:0] em, input int abort_at, input int repulse_at,
                       input int ncyc);
    expect_mask = em;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    record(0);
    done_k = -1;
    n_done = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      record(k);
      if (done === 1'b1) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      abort = (k == abort_at);
      start = (k == repulse_at);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_abcd",  32'(abcd), 32'h0);
    chk("rst_sn",    32'(sn), 32'h1);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_table", 32'(table_out), 32'h0);
    chk("rst_pass",  32'(pass), 32'h0);
    chk("rst_blank", 32'(blank_err), 32'h0);
    chk("rst_err",   32'(err_idx), 32'h0);

    // Nominal sweep, started on the very first edge after reset release.
    rst_n = 1'b1;
    fn = 16'h32A4;
    sweep(16'h32A4, 0, 0, 70);
    chk("a_busy0",  32'(busy_r[0]), 32'h1);
    chk("a_sn_blank", 32'(sn_r[0]), 32'h1);
    for (int k = 1; k <= 48; k++) begin
      chk($sformatf("a_sn_k%0d", k), 32'(sn_r[k]), 32'h0);
      chk($sformatf("a_abcd_k%0d", k), 32'(abcd_r[k]), 32'((k - 1) / 3));
    end
    chk("a_busy48", 32'(busy_r[48]), 32'h1);
    chk("a_busy49", 32'(busy_r[49]), 32'h0);
    chk("a_sn49",   32'(sn_r[49]), 32'h1);
    chk("a_done_k", 32'(done_k), 32'd50);
    chk("a_ndone",  32'(n_done), 32'd1);
    chk("a_table",  32'(table_out), 32'h32A4);
    chk("a_pass",   32'(pass), 32'h1);
    chk("a_err",    32'(err_idx), 32'h0);
    chk("a_blank",  32'(blank_err), 32'h0);

    // Expectation differs in bit 2.
    sweep(16'h32A0, 0, 0, 70);
    chk("b_done_k", 32'(done_k), 32'd50);
    chk("b_table",  32'(table_out), 32'h32A4);
    chk("b_pass",   32'(pass), 32'h0);
    chk("b_err",    32'(err_idx), 32'h2);

    // Abort at cycle 20 of a sweep that would otherwise record 16'h1234.
    fn = 16'h1234;
    sweep(16'h1234, 20, 0, 70);
    chk("c_busy20", 32'(busy_r[20]), 32'h1);
    chk("c_busy21", 32'(busy_r[21]), 32'h0);
    chk("c_sn21",   32'(sn_r[21]), 32'h1);
    chk("c_ndone",  32'(n_done), 32'd0);
    chk("c_table",  32'(table_out), 32'h32A4);
    chk("c_pass",   32'(pass), 32'h0);
    chk("c_err",    32'(err_idx), 32'h2);

    // Mux output stuck low while disabled.
    fn = 16'h32A4;
    force0 = 1'b1;
    sweep(16'h32A4, 0, 0, 70);
    force0 = 1'b0;
    chk("d_blank0", 32'(blank_r[0]), 32'h0);
    chk("d_blank1", 32'(blank_r[1]), 32'h1);
    chk("d_done_k", 32'(done_k), 32'd50);
    chk("d_table",  32'(table_out), 32'h32A4);
    chk("d_pass",   32'(pass), 32'h1);
    chk("d_blank_end", 32'(blank_err), 32'h1);

    // Reset asserted while vector 7 is on the bus.
    fn = 16'hBEEF;
    expect_mask = 16'hBEEF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    cnt = 0;
    while (!hit && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (abcd == 4'd7) hit = 1'b1;
    end
    chk("e_reach7", 32'(hit), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("e_busy",  32'(busy), 32'h0);
    chk("e_sn",    32'(sn), 32'h1);
    chk("e_abcd",  32'(abcd), 32'h0);
    chk("e_done",  32'(done), 32'h0);
    chk("e_table", 32'(table_out), 32'h0);
    chk("e_blank", 32'(blank_err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(16'hBEEF, 0, 0, 70);
    chk("e_abcd1",  32'(abcd_r[1]), 32'h0);
    chk("e_done_k", 32'(done_k), 32'd50);
    chk("e_ndone",  32'(n_done), 32'd1);
    chk("e_table2", 32'(table_out), 32'hBEEF);
    chk("e_pass",   32'(pass), 32'h1);

    // Start re-pulsed mid-sweep must be neither honoured nor queued.
    fn = 16'h5A5A;
    sweep(16'h5A5A, 0, 10, 70);
    chk("f_done_k", 32'(done_k), 32'd50);
    chk("f_ndone",  32'(n_done), 32'd1);
    chk("f_busy_end", 32'(busy), 32'h0);
    chk("f_table",  32'(table_out), 32'h5A5A);

    // Start together with abort in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("g_busy", 32'(busy), 32'h0);
    chk("g_sn",   32'(sn), 32'h1);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    chk("g_ndone", 32'(cnt), 32'd0);
    chk("g_table", 32'(table_out), 32'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_scan_ctrl.md
TT_SCAN_CTRL -- requirements
Module: tt_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, number of cycles each input vector is held before sampling (legal range 1..15).
REQ-002 Parameter SAMPLE_ON_LAST, default 1. When 1, y_in is sampled in the last settle cycle. When 0, y_in is sampled one cycle after the last settle cycle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request one full 16-vector sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate the sweep in progress.
REQ-007 expect_mask  input  16  expected function output, bit i = value at vector i; captured when start is accepted.
REQ-008 abcd  output  4  vector driven to the 8:1-mux datapath: abcd[3:1] = select {a,b,c}, abcd[0] = data-derive input d.
REQ-009 sn  output  1  active-low strobe to the mux; 1 disables it, forcing its output to 1.
REQ-010 y_in  input  1  mux output returned to the controller.
REQ-011 busy  output  1  sweep in progress.
REQ-012 done  output  1  one-cycle pulse when a sweep completes.
REQ-013 table_out  output  16  measured truth table of the last completed sweep.
REQ-014 pass  output  1  table_out equals captured expect_mask; valid from done onward.
REQ-015 blank_err  output  1  y_in was 0 while sn=1 during the BLANK check.
REQ-016 err_idx  output  4  lowest vector index where the measured table differs from the expected table; 0 when pass=1.

Function
REQ-017 The states SHALL be IDLE, BLANK, DRIVE, SAMPLE and DONE, encoded as an enum.
REQ-018 IDLE: sn=1, busy=0; start=1 and abort=0 -> BLANK, capture expect_mask, clear the shadow table and the vector index.
REQ-019 BLANK: one cycle, sn=1; blank_err <= ~y_in; -> DRIVE.
REQ-020 DRIVE: sn=0, abcd=vector index; hold for SETTLE_CYC cycles via the settle counter.
REQ-021 SAMPLE: write y_in into shadow bit [index]; if index=15 -> DONE, else index+1 and -> DRIVE.
REQ-022 With SAMPLE_ON_LAST=1, the SAMPLE state SHALL be merged into the final DRIVE cycle, so each vector takes SETTLE_CYC cycles. With SAMPLE_ON_LAST=0, each vector takes SETTLE_CYC+1 cycles.
REQ-023 abcd SHALL change only on the DRIVE entry edge; sn SHALL stay 0 across consecutive vectors.
REQ-024 DONE: one cycle; done=1, table_out <= shadow, pass and err_idx are updated, sn=1; -> IDLE.
REQ-025 busy SHALL be 1 exactly in the BLANK, DRIVE and SAMPLE states.
REQ-026 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 abort in BLANK, DRIVE or SAMPLE -> IDLE on the next edge: no done pulse, and table_out, pass and err_idx are left unchanged.
REQ-028 abort has priority over start when both are asserted in IDLE.
REQ-029 The vector index is 4-bit; the increment after index 15 SHALL be suppressed and SHALL NOT wrap.

Reset
REQ-030 While rst_n=0: state=IDLE, abcd=0, sn=1, busy=0, done=0, table_out=0, pass=0, blank_err=0, err_idx=0, index=0, settle counter=0.
REQ-031 A reset asserted mid-sweep SHALL discard the sweep without producing a done pulse.
REQ-032 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 Package tt_scan_pkg SHALL hold the state enum, N_VEC=16 and the default for SETTLE_CYC.
REQ-034 One sub-module, tt_vec_counter, SHALL contain the vector index and settle counter and provide last_settle and last_vec flags.
REQ-035 The bench SHALL contain a behavioural 8:1 strobed mux model (output 1 when disabled) that closes the loop from abcd/sn back to y_in.

Verification
REQ-036 SETTLE_CYC=2, SAMPLE_ON_LAST=0, mux programmed for function 16'h32A4, expect_mask=16'h32A4, start -> done exactly 50 cycles after the start edge, table_out=16'h32A4, pass=1, err_idx=0, blank_err=0.
REQ-037 Same as REQ-036 with expect_mask=16'h32A0 -> pass=0, err_idx=2.
REQ-038 abort at cycle 20 of the sweep -> busy=0 and sn=1 next cycle, no done pulse, table_out keeps its previous value.
REQ-039 Model forces y_in=0 while sn=1 -> blank_err=1 after BLANK; the sweep still completes.
REQ-040 rst_n pulled low at vector 7, then start again -> full sweep from vector 0 with correct table_out.
REQ-041 start re-pulsed during busy, and start with abort asserted in IDLE -> both ignored, exactly one done pulse per accepted start.
